// File: rtl/jala_pkg.sv
// rtl/jala_pkg.sv - Shared constants and fetch-entry type for the Jala rv32i pipeline.
package jala_pkg;

    localparam int XLEN = 32;
    localparam logic [31:0] RV_NOP = 32'h0000_0013;
    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
        logic            misaligned;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - Synchronous power-of-two FIFO with push/pop/flush and occupancy count.
module fetch_fifo
    import jala_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = logic [31:0]
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         push,
    input  T                             push_data,
    input  logic                         pop,
    output T                             head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    T                mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    // A push into a full FIFO is only honoured when a pop frees the slot in the same cycle.
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - Jala fetch front end: PC generator, credit-limited issue, prefetch buffer.
// Optional FETCH_MISALIGN_TRAP_EN turns misaligned redirect targets into a NOP trap entry.
module fetch_unit
    import jala_pkg::*;
#(
    parameter int              XLEN         = jala_pkg::XLEN,
    parameter int              DEPTH        = 4,
    parameter logic [XLEN-1:0] RESET_VECTOR = jala_pkg::RESET_VECTOR
) (
    input  logic            clk,
    input  logic            reset,
    output logic            op_inst_req,
    output logic [XLEN-1:0] op_inst_addr,
    input  logic            ip_inst_valid,
    input  logic [XLEN-1:0] ip_inst_from_imem,
    input  logic            ip_redirect_valid,
    input  logic [XLEN-1:0] ip_redirect_pc,
    output logic            op_if_valid,
    input  logic            ip_if_ready,
    output logic [XLEN-1:0] op_if_inst,
    output logic [XLEN-1:0] op_if_pc,
    output logic            op_if_misaligned
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pcq_head;
    logic [XLEN-1:0] redirect_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   drop;
    logic [CW-1:0]   buf_count;
    logic [CW-1:0]   pcq_count;
    logic            halted;
    logic            trap_pending;
    logic            redirect_misaligned;
    logic            resp_take;
    logic            resp_keep;
    logic            issue;
    logic            trap_push;
    logic            buf_push;
    logic            buf_pop;
    fetch_entry_t    buf_in;
    fetch_entry_t    buf_head;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign redirect_pc         = ip_redirect_pc;
    assign redirect_misaligned = (ip_redirect_pc[1:0] != 2'b00);
`else
    assign redirect_pc         = ip_redirect_pc & ~XLEN'(3);
    assign redirect_misaligned = 1'b0;
`endif

    // Responses with nothing outstanding (e.g. right after reset) are stale and ignored.
    assign resp_take = ip_inst_valid && (outstanding != '0);
    assign resp_keep = resp_take && (drop == '0) && !ip_redirect_valid;
    assign issue     = !reset && !halted && !ip_redirect_valid
                       && (({1'b0, outstanding} + {1'b0, buf_count}) < (CW+1)'(DEPTH));
    assign trap_push = trap_pending && (outstanding == '0) && !ip_redirect_valid;
    assign buf_push  = resp_keep || trap_push;
    assign buf_pop   = op_if_valid && ip_if_ready && !ip_redirect_valid;

    always_comb begin
        buf_in = '{inst: ip_inst_from_imem, pc: pcq_head, misaligned: 1'b0};
        if (trap_push) buf_in = '{inst: RV_NOP, pc: pc, misaligned: 1'b1};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc           <= RESET_VECTOR;
            outstanding  <= '0;
            drop         <= '0;
            halted       <= 1'b0;
            trap_pending <= 1'b0;
        end else if (ip_redirect_valid) begin
            // Everything still in flight after this cycle belongs to the old path.
            pc           <= redirect_pc;
            outstanding  <= outstanding - CW'(resp_take);
            drop         <= outstanding - CW'(resp_take);
            halted       <= redirect_misaligned;
            trap_pending <= redirect_misaligned;
        end else begin
            if (issue) pc <= pc + XLEN'(4);
            outstanding <= outstanding + CW'(issue) - CW'(resp_take);
            if (resp_take && (drop != '0)) drop <= drop - CW'(1);
            if (trap_push) trap_pending <= 1'b0;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH), .T(logic [XLEN-1:0])) u_pc_queue (
        .clk       (clk),
        .reset     (reset),
        .flush     (ip_redirect_valid),
        .push      (issue),
        .push_data (pc),
        .pop       (resp_keep),
        .head      (pcq_head),
        .count     (pcq_count)
    );

    fetch_fifo #(.DEPTH(DEPTH), .T(fetch_entry_t)) u_prefetch (
        .clk       (clk),
        .reset     (reset),
        .flush     (ip_redirect_valid),
        .push      (buf_push),
        .push_data (buf_in),
        .pop       (buf_pop),
        .head      (buf_head),
        .count     (buf_count)
    );

    // Credit accounting keeps a kept response matched to a queued PC and a free buffer slot.
    always_ff @(posedge clk) begin
        if (!reset && resp_keep) begin
            assert ((pcq_count != '0) && ((buf_count != CW'(DEPTH)) || buf_pop));
        end
    end

    assign op_inst_req      = issue;
    assign op_inst_addr     = pc;
    assign op_if_valid      = (buf_count != '0);
    assign op_if_inst       = op_if_valid ? buf_head.inst : '0;
    assign op_if_pc         = op_if_valid ? buf_head.pc : '0;
    assign op_if_misaligned = op_if_valid && buf_head.misaligned;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch front end for the Jala 5-stage rv32i pipeline. It replaces the single-register PC/next-PC logic with a PC generator, a credit-limited request issuer toward instruction memory, and an in-order prefetch buffer feeding decode through a valid/ready handshake. Redirects from execute flush the buffer and discard in-flight responses.

## Interface
Parameters:
- XLEN, 32: address and instruction width.
- DEPTH, 4: prefetch buffer entries. Power of two, at least 2.
- RESET_VECTOR, 32'h0000_0000: PC after reset.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- op_inst_req  out  1  fetch request valid; imem accepts every asserted cycle
- op_inst_addr  out  XLEN  fetch address
- ip_inst_valid  in  1  imem response valid; responses are in order, at least 1 cycle after request
- ip_inst_from_imem  in  XLEN  response instruction
- ip_redirect_valid  in  1  control-flow redirect from execute
- ip_redirect_pc  in  XLEN  redirect target
- op_if_valid  out  1  buffered instruction available to decode
- ip_if_ready  in  1  decode accepts this cycle
- op_if_inst  out  XLEN  instruction
- op_if_pc  out  XLEN  PC of op_if_inst
- op_if_misaligned  out  1  misaligned-target flag (only with FETCH_MISALIGN_TRAP_EN; tied 0 otherwise)

## Operation
- Registered state: PC, outstanding counter (0..DEPTH), drop counter (0..DEPTH), in-flight PC queue, prefetch buffer.
- Issue: op_inst_req = !reset && !halted && (outstanding + count) < DEPTH. op_inst_addr = PC. On issue, PC <= PC + 4 (mod 2^XLEN) and the PC is pushed to the in-flight PC queue.
- Response: ip_inst_valid with drop == 0 pushes {inst, PC} into the buffer and decrements outstanding. With drop > 0, the response is discarded and both drop and outstanding decrement.
- Credit rule guarantees the buffer never overflows. A response arriving while the buffer is full and no drop is pending is a protocol violation and must never occur.
- Output: op_if_valid = buffer not empty. A pop occurs when op_if_valid && ip_if_ready. op_if_inst/op_if_pc hold stable while valid && !ready.
- Redirect (highest priority): buffer emptied; drop <= outstanding minus any same-cycle response; PC <= ip_redirect_pc. There is no issue in the redirect cycle. A pop in that cycle is ignored.
- Push and pop in the same cycle: count unchanged, both performed.

## Timing
- Reset values: PC = RESET_VECTOR, op_inst_req = 0, op_if_valid = 0, op_if_inst = 0, op_if_pc = 0, op_if_misaligned = 0, counters 0, buffer empty.
- First cycle after reset deasserts: op_inst_req = 1, op_inst_addr = RESET_VECTOR.
- Response at cycle N leads to op_if_valid at N+1 (no bypass).
- Redirect at cycle R leads to the first request to the target at R+1.
- Steady state with 1-cycle imem and ip_if_ready held high: one instruction per cycle.
- Reset mid-operation clears everything. Responses arriving in the cycle after reset are ignored because outstanding is 0 and there are no pending drops.

## Configuration
- FETCH_MISALIGN_TRAP_EN defined: a redirect with ip_redirect_pc[1:0] != 0 sets halted. Issue stops, and after in-flight drops drain, the buffer presents op_if_valid = 1, op_if_misaligned = 1, op_if_pc = the target, and op_if_inst = 32'h0000_0013 (NOP). The next redirect or reset clears halted.
- Undefined: ip_redirect_pc[1:0] is forced to 0. op_if_misaligned is constant 0.

## Structure
- Shared package jala_pkg: XLEN, RV_NOP = 32'h0000_0013, default RESET_VECTOR, and a fetch-entry typedef {inst, pc, misaligned}.
- Sub-module fetch_fifo: synchronous DEPTH-entry FIFO with push/pop/flush and count output. It is instantiated for the prefetch buffer; the in-flight PC queue also uses fetch_fifo or an equivalent.

## Test plan
- Reset release, 1-cycle imem, ready high -> requests at 0x0, 0x4, 0x8, …; decode sees pc 0x0 with its instruction 2 cycles after reset deasserts, then one per cycle.
- ip_if_ready low for 10 cycles, DEPTH=4 -> op_inst_req drops after outstanding + count reaches 4; outputs stable; no request resumes until a pop.
- Redirect to 0x100 with 3 requests outstanding -> next 3 responses discarded; next op_if_pc = 0x100; no stale PC ever appears on the output.
- Redirect in the same cycle as a response and a pop -> buffer empty next cycle; drop count correct; first request to the target at R+1.
- PC 0xFFFF_FFFC -> next request wraps to 0x0000_0000.
- With FETCH_MISALIGN_TRAP_EN, redirect to 0x102 -> no requests issued; op_if_valid = 1, op_if_misaligned = 1, op_if_pc = 0x102; a redirect to 0x200 resumes normal fetch.
